// File: rtl/intra_refpos_gen_if.sv
// rtl/intra_refpos_gen_if.sv - Handshake and reference-position bus of intra_refpos_gen.
interface intra_refpos_gen_if;
    logic        start;
    logic [5:0]  mode;
    logic [2:0]  tuSize;
    logic        bStop;
    logic        busy;
    logic        valid;
    logic        done;
    logic        err;
    logic [2:0]  X;
    logic [2:0]  Y;
    logic [3:0]  preStage;
    logic [47:0] ref_pos;
    logic [15:0] ref_flag;

    modport master (
        output start, mode, tuSize, bStop,
        input  busy, valid, done, err, X, Y, preStage, ref_pos, ref_flag
    );

    modport slave (
        input  start, mode, tuSize, bStop,
        output busy, valid, done, err, X, Y, preStage, ref_pos, ref_flag
    );
endinterface

// File: rtl/intra_refpos_gen.sv
// rtl/intra_refpos_gen.sv - Walks a TU in 4x4 sub-blocks issuing 8 angular reference positions/flags per beat.
// Optional macro INTRA_REFPOS_REG_OUT_EN adds one extra output register stage.
module intra_refpos_gen #(
    parameter bit isChroma = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    intra_refpos_gen_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, LAST} state_t;

    function automatic logic signed [11:0] angleOf(input logic [5:0] m);
        case (m)
            6'd2:  angleOf =  12'sd32;
            6'd3:  angleOf =  12'sd26;
            6'd4:  angleOf =  12'sd21;
            6'd5:  angleOf =  12'sd17;
            6'd6:  angleOf =  12'sd13;
            6'd7:  angleOf =  12'sd9;
            6'd8:  angleOf =  12'sd5;
            6'd9:  angleOf =  12'sd2;
            6'd11: angleOf = -12'sd2;
            6'd12: angleOf = -12'sd5;
            6'd13: angleOf = -12'sd9;
            6'd14: angleOf = -12'sd13;
            6'd15: angleOf = -12'sd17;
            6'd16: angleOf = -12'sd21;
            6'd17: angleOf = -12'sd26;
            6'd18: angleOf = -12'sd32;
            6'd19: angleOf = -12'sd26;
            6'd20: angleOf = -12'sd21;
            6'd21: angleOf = -12'sd17;
            6'd22: angleOf = -12'sd13;
            6'd23: angleOf = -12'sd9;
            6'd24: angleOf = -12'sd5;
            6'd25: angleOf = -12'sd2;
            6'd27: angleOf =  12'sd2;
            6'd28: angleOf =  12'sd5;
            6'd29: angleOf =  12'sd9;
            6'd30: angleOf =  12'sd13;
            6'd31: angleOf =  12'sd17;
            6'd32: angleOf =  12'sd21;
            6'd33: angleOf =  12'sd26;
            6'd34: angleOf =  12'sd32;
            default: angleOf = 12'sd0;
        endcase
    endfunction

    function automatic logic [12:0] invOf(input logic signed [11:0] a);
        case (a)
            -12'sd2:  invOf = 13'd4096;
            -12'sd5:  invOf = 13'd1638;
            -12'sd9:  invOf = 13'd910;
            -12'sd13: invOf = 13'd630;
            -12'sd17: invOf = 13'd482;
            -12'sd21: invOf = 13'd390;
            -12'sd26: invOf = 13'd315;
            -12'sd32: invOf = 13'd256;
            default:  invOf = 13'd0;
        endcase
    endfunction

    // Returns {flag, pos} for sample i of line r within the given beat.
    function automatic logic [7:0] calcEntry(
        input logic [5:0] m,
        input logic [2:0] bx,
        input logic [2:0] by,
        input logic       bh,
        input logic       r,
        input logic [1:0] i
    );
        logic              vert;
        logic [4:0]        line;
        logic [4:0]        samp;
        logic signed [11:0] ang;
        logic signed [11:0] iIdx;
        logic signed [11:0] k;
        logic [11:0]       negK;
        logic [24:0]       prod;
        logic [1:0]        f;
        logic [5:0]        p;
        vert = (m >= 6'd18);
        line = vert ? {by, bh, r} : {bx, bh, r};
        samp = vert ? {bx, i} : {by, i};
        ang  = angleOf(m);
        iIdx = (($signed({7'd0, line}) + 12'sd1) * ang) >>> 5;
        k    = $signed({7'd0, samp}) + iIdx + 12'sd1;
        negK = 12'(-k);
        prod = 25'(negK) * 25'(invOf(ang));
        f    = 2'd0;
        p    = 6'd0;
        if (m < 6'd2) begin
            f = r ? 2'd1 : 2'd0;
            p = {1'b0, (r ? by : bx), i};
        end else if (k > 12'sd0) begin
            f = vert ? 2'd0 : 2'd1;
            p = 6'(k - 12'sd1);
        end else if (k == 12'sd0) begin
            f = 2'd2;
            p = 6'd0;
        end else begin
            f = vert ? 2'd1 : 2'd0;
            p = 6'(((prod + 25'd128) >> 8) - 25'd1);
        end
        return {f, p};
    endfunction

    state_t      state;
    logic [5:0]  modeReg;
    logic [2:0]  nm1;
    logic        coreBusy, coreValid, coreDone, coreErr, coreH;
    logic [2:0]  coreX, coreY;
    logic [3:0]  corePre;
    logic [47:0] corePos;
    logic [15:0] coreFlag;

    logic        legal;
    logic [5:0]  calcMode;
    logic [2:0]  calcX, calcY;
    logic        calcH;
    logic        nextLast;
    logic [47:0] nextPos;
    logic [15:0] nextFlag;

    assign legal = (bus.tuSize >= 3'd2) && (bus.tuSize <= (isChroma ? 3'd4 : 3'd5)) &&
                   (bus.mode <= 6'd34);

    // In IDLE the first beat is built straight from the start inputs so it lands one cycle later.
    always_comb begin
        logic [7:0] e;
        logic [2:0] tIdx;
        calcMode = modeReg;
        calcX    = coreX;
        calcY    = coreY;
        calcH    = ~coreH;
        nextPos  = '0;
        nextFlag = '0;
        e        = '0;
        tIdx     = '0;
        if (state == IDLE) begin
            calcMode = bus.mode;
            calcX    = 3'd0;
            calcY    = 3'd0;
            calcH    = 1'b0;
        end else if (coreH) begin
            if (coreX == nm1) begin
                calcX = 3'd0;
                calcY = coreY + 3'd1;
            end else begin
                calcX = coreX + 3'd1;
            end
        end
        for (int t = 0; t < 8; t++) begin
            tIdx = 3'(t);
            e    = calcEntry(calcMode, calcX, calcY, calcH, tIdx[2], tIdx[1:0]);
            nextPos[47-6*t -: 6]  = e[5:0];
            nextFlag[15-2*t -: 2] = e[7:6];
        end
    end

    assign nextLast = (calcX == nm1) && (calcY == nm1) && calcH;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            modeReg   <= '0;
            nm1       <= '0;
            coreBusy  <= 1'b0;
            coreValid <= 1'b0;
            coreDone  <= 1'b0;
            coreErr   <= 1'b0;
            coreH     <= 1'b0;
            coreX     <= '0;
            coreY     <= '0;
            corePre   <= '0;
            corePos   <= '0;
            coreFlag  <= '0;
        end else if (!bus.bStop) begin
            case (state)
                IDLE: begin
                    coreDone  <= 1'b0;
                    coreErr   <= 1'b0;
                    coreValid <= 1'b0;
                    coreBusy  <= 1'b0;
                    if (bus.start) begin
                        if (legal) begin
                            state     <= RUN;
                            modeReg   <= bus.mode;
                            nm1       <= 3'((4'd1 << (bus.tuSize - 3'd2)) - 4'd1);
                            coreBusy  <= 1'b1;
                            coreValid <= 1'b1;
                            coreX     <= calcX;
                            coreY     <= calcY;
                            coreH     <= calcH;
                            corePre   <= 4'd0;
                            corePos   <= nextPos;
                            coreFlag  <= nextFlag;
                        end else begin
                            coreErr <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    coreX    <= calcX;
                    coreY    <= calcY;
                    coreH    <= calcH;
                    corePre  <= corePre + 4'd1;
                    corePos  <= nextPos;
                    coreFlag <= nextFlag;
                    if (nextLast) begin
                        state    <= LAST;
                        coreDone <= 1'b1;
                    end
                end
                LAST: begin
                    state     <= IDLE;
                    coreBusy  <= 1'b0;
                    coreValid <= 1'b0;
                    coreDone  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [77:0] coreOut;
    logic [77:0] outReg;
    assign coreOut = {coreBusy, coreValid, coreDone, coreErr, coreX, coreY, corePre, corePos, coreFlag};

`ifdef INTRA_REFPOS_REG_OUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            outReg <= '0;
        end else if (!bus.bStop) begin
            outReg <= coreOut;
        end
    end
`else
    assign outReg = coreOut;
`endif

    assign {bus.busy, bus.valid, bus.done, bus.err, bus.X, bus.Y, bus.preStage,
            bus.ref_pos, bus.ref_flag} = outReg;
endmodule

// File: tb/tb_intra_refpos_gen.sv
// tb/tb_intra_refpos_gen.sv - Self-checking bench for intra_refpos_gen against a beat-level reference model.
module tb_intra_refpos_gen;
`ifdef INTRA_REFPOS_REG_OUT_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct packed {
        logic [2:0]  x;
        logic [2:0]  y;
        logic [3:0]  pre;
        logic [47:0] pos;
        logic [15:0] flag;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    intra_refpos_gen_if ifc();

    intra_refpos_gen #(.isChroma(1'b0)) dut (.clk(clk), .rst(rst), .bus(ifc));

    always #5 clk = ~clk;

    int    total = 0;
    int    bad = 0;
    int    beatsSeen = 0;
    beat_t expQ[$];
    beat_t cur;
    logic  stallSeen = 1'b0;
    logic [2:0] doneX, doneY;
    logic [3:0] donePre;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic int angleOf(input int m);
        int mg[9] = '{0, 2, 5, 9, 13, 17, 21, 26, 32};
        if (m >= 2 && m <= 10) return mg[10-m];
        if (m >= 11 && m <= 18) return -mg[m-10];
        if (m >= 19 && m <= 26) return -mg[26-m];
        if (m >= 27 && m <= 34) return mg[m-26];
        return 0;
    endfunction

    // Model: inverse angle as rounded 8192/|angle|.
    task automatic buildTu(input int md, input int sz);
        int n, pre, a, inv, line, samp, iIdx, k, f, p;
        logic [47:0] pv;
        logic [15:0] fv;
        beat_t b;
        n = 1 << (sz - 2);
        pre = 0;
        a = angleOf(md);
        inv = (a < 0) ? (8192 + (-a) / 2) / (-a) : 0;
        for (int y = 0; y < n; y++)
            for (int x = 0; x < n; x++)
                for (int h = 0; h < 2; h++) begin
                    for (int t = 0; t < 8; t++) begin
                        if (md < 2) begin
                            f = t / 4;
                            p = (t / 4 == 0) ? 4 * x + t % 4 : 4 * y + t % 4;
                        end else begin
                            line = (md >= 18) ? 4 * y + 2 * h + t / 4 : 4 * x + 2 * h + t / 4;
                            samp = (md >= 18) ? 4 * x + t % 4 : 4 * y + t % 4;
                            iIdx = ((line + 1) * a) >>> 5;
                            k = samp + iIdx + 1;
                            if (k >= 1) begin
                                f = (md >= 18) ? 0 : 1;
                                p = k - 1;
                            end else if (k == 0) begin
                                f = 2;
                                p = 0;
                            end else begin
                                f = (md >= 18) ? 1 : 0;
                                p = ((-k) * inv + 128) / 256 - 1;
                            end
                        end
                        pv[47-6*t -: 6] = 6'(p);
                        fv[15-2*t -: 2] = 2'(f);
                    end
                    b.x = 3'(x);
                    b.y = 3'(y);
                    b.pre = 4'(pre);
                    b.pos = pv;
                    b.flag = fv;
                    b.last = (x == n - 1) && (y == n - 1) && (h == 1);
                    expQ.push_back(b);
                    pre = (pre + 1) % 16;
                end
    endtask

    function automatic logic [47:0] pk6(input int a0, a1, a2, a3, a4, a5, a6, a7);
        return {6'(a0), 6'(a1), 6'(a2), 6'(a3), 6'(a4), 6'(a5), 6'(a6), 6'(a7)};
    endfunction

    function automatic logic [15:0] pk2(input int a0, a1, a2, a3, a4, a5, a6, a7);
        return {2'(a0), 2'(a1), 2'(a2), 2'(a3), 2'(a4), 2'(a5), 2'(a6), 2'(a7)};
    endfunction

    always @(posedge clk) stallSeen <= ifc.bStop;

    // A stalled edge leaves the previous beat on the outputs, so the same expectation is reused.
    always @(negedge clk) begin
        if (!rst) begin
            if (ifc.valid) begin
                if (!stallSeen) begin
                    if (expQ.size() == 0) begin
                        check("unexpected_valid", 1, 0);
                    end else begin
                        cur = expQ.pop_front();
                        beatsSeen++;
                    end
                end
                check("beat_x", ifc.X, cur.x);
                check("beat_y", ifc.Y, cur.y);
                check("beat_pre", ifc.preStage, cur.pre);
                check("beat_pos", ifc.ref_pos, cur.pos);
                check("beat_flag", ifc.ref_flag, cur.flag);
                check("beat_done", ifc.done, cur.last);
                check("beat_busy", ifc.busy, 1);
            end else begin
                check("idle_done", ifc.done, 0);
            end
        end
    end

    task automatic runTu(input int md, input int sz, input int stallAt, input int stallLen,
                         input int ignoreAt, input int rstAt);
        int cyc, startBeats, expBeats, n, vcount;
        bit sawDone, rstHit;
        n = 1 << (sz - 2);
        expBeats = 2 * n * n;
        startBeats = beatsSeen;
        @(negedge clk);
        #1;
        ifc.start = 1'b1;
        ifc.mode = 6'(md);
        ifc.tuSize = 3'(sz);
        @(posedge clk);
        #1 ifc.start = 1'b0;
        repeat (LAT) @(negedge clk);
        check("first_valid", ifc.valid, 1);
        cyc = 0;
        sawDone = 0;
        rstHit = 0;
        while (!sawDone && !rstHit && cyc < 400) begin
            if (ifc.valid && ifc.done) begin
                sawDone = 1;
                doneX = ifc.X;
                doneY = ifc.Y;
                donePre = ifc.preStage;
            end else if (cyc == rstAt) begin
                #1 rst = 1'b1;
                @(negedge clk);
                check("rst_busy", ifc.busy, 0);
                check("rst_valid", ifc.valid, 0);
                check("rst_done", ifc.done, 0);
                check("rst_payload", {ifc.X, ifc.Y, ifc.preStage, ifc.ref_pos, ifc.ref_flag}, 0);
                #1 rst = 1'b0;
                expQ.delete();
                vcount = 0;
                repeat (20) begin
                    @(negedge clk);
                    if (ifc.valid || ifc.done || ifc.busy) vcount++;
                end
                check("rst_no_resume", vcount, 0);
                rstHit = 1;
            end else begin
                #1;
                if (cyc == stallAt) ifc.bStop = 1'b1;
                if (cyc == stallAt + stallLen) ifc.bStop = 1'b0;
                if (cyc == ignoreAt) begin
                    ifc.start = 1'b1;
                    ifc.mode = 6'd0;
                    ifc.tuSize = 3'd2;
                end else begin
                    ifc.start = 1'b0;
                end
                @(negedge clk);
                cyc++;
            end
        end
        if (!rstHit) begin
            check("done_seen", sawDone, 1);
            @(negedge clk);
            check("after_busy", ifc.busy, 0);
            check("after_valid", ifc.valid, 0);
            check("beat_count", beatsSeen - startBeats, expBeats);
            check("queue_empty", expQ.size(), 0);
        end
    endtask

    task automatic errTry(input int md, input int sz);
        @(negedge clk);
        #1;
        ifc.start = 1'b1;
        ifc.mode = 6'(md);
        ifc.tuSize = 3'(sz);
        @(posedge clk);
        #1 ifc.start = 1'b0;
        repeat (LAT) @(negedge clk);
        check("err_pulse", ifc.err, 1);
        check("err_busy", ifc.busy, 0);
        check("err_valid", ifc.valid, 0);
        @(negedge clk);
        check("err_drop", ifc.err, 0);
        check("err_busy2", ifc.busy, 0);
    endtask

    initial begin
        ifc.start = 1'b0;
        ifc.mode = '0;
        ifc.tuSize = '0;
        ifc.bStop = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {ifc.busy, ifc.valid, ifc.done, ifc.err, ifc.X, ifc.Y,
                                ifc.preStage, ifc.ref_pos, ifc.ref_flag}, 0);
        #1 rst = 1'b0;

        buildTu(26, 2);
        check("pin26_pos", expQ[0].pos, pk6(0, 1, 2, 3, 0, 1, 2, 3));
        check("pin26_flag", expQ[0].flag, pk2(0, 0, 0, 0, 0, 0, 0, 0));
        check("pin26_last", expQ[1].last, 1);
        runTu(26, 2, -1, 0, -1, -1);

        buildTu(18, 2);
        check("pin18_pos", expQ[0].pos, pk6(0, 0, 1, 2, 0, 0, 0, 1));
        check("pin18_flag", expQ[0].flag, pk2(2, 0, 0, 0, 1, 2, 0, 0));
        runTu(18, 2, -1, 0, -1, -1);

        buildTu(34, 2);
        check("pin34_pos", expQ[0].pos, pk6(1, 2, 3, 4, 2, 3, 4, 5));
        check("pin34_flag", expQ[0].flag, pk2(0, 0, 0, 0, 0, 0, 0, 0));
        runTu(34, 2, -1, 0, -1, -1);

        buildTu(10, 3);
        check("pin10_pos", expQ[0].pos, pk6(0, 1, 2, 3, 0, 1, 2, 3));
        check("pin10_flag", expQ[0].flag, pk2(1, 1, 1, 1, 1, 1, 1, 1));
        check("pin10_x2", expQ[2].x, 1);
        check("pin10_pre7", expQ[7].pre, 7);
        runTu(10, 3, -1, 0, 2, -1);

        buildTu(2, 5);
        runTu(2, 5, 40, 3, -1, -1);
        check("done_x", doneX, 7);
        check("done_y", doneY, 7);
        check("done_pre", donePre, 15);

        buildTu(30, 4);
        runTu(30, 4, -1, 0, -1, 5);

        errTry(5, 6);
        errTry(35, 3);
        errTry(7, 1);

        buildTu(14, 3);
        runTu(14, 3, 3, 2, -1, -1);

        buildTu(1, 3);
        runTu(1, 3, -1, 0, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
